// File: rtl/taho_pkg.sv
// Shared definitions for the tachometer gate scheduler: widths and stream FSM states.
package taho_pkg;
  localparam int TAHO_W   = 16;
  localparam int CH_IDX_W = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } stream_state_e;
endpackage

// File: rtl/taho_gate_timer.sv
// Window timer: free-running tick while enabled, registered 'sec' gate and the
// snapshot-event pulse, with the first (partial) window after enable suppressed.
module taho_gate_timer
  import taho_pkg::*;
#(
  parameter int GATE_TICKS = 1000000,
  parameter int SEC_HIGH   = 500000,
  parameter int LATCH_DLY  = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic sec,
  output logic snap_evt
);

  localparam int TICK_W = $clog2(GATE_TICKS);
  localparam logic [TICK_W-1:0] LAST_T  = TICK_W'(GATE_TICKS - 1);
  localparam logic [TICK_W-1:0] SEC_T   = TICK_W'(SEC_HIGH);
  localparam logic [TICK_W-1:0] LATCH_T = TICK_W'(LATCH_DLY);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic              sec_q, sec_d;
  logic              first_win_q, first_win_d;
  logic              at_latch_s;

  assign at_latch_s = enable && (tick_q == LATCH_T);
  assign snap_evt   = at_latch_s && !first_win_q;
  assign sec        = sec_q;

  always_comb begin
    tick_d      = tick_q;
    sec_d       = 1'b0;
    first_win_d = first_win_q;
    if (!enable) begin
      // Holding tick at zero while disabled makes re-enable start a clean window.
      tick_d      = '0;
      first_win_d = 1'b1;
    end else begin
      tick_d = (tick_q == LAST_T) ? '0 : tick_q + 1'b1;
      sec_d  = (tick_q < SEC_T);
      if (at_latch_s) first_win_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_q      <= '0;
      sec_q       <= 1'b0;
      first_win_q <= 1'b1;
    end else begin
      tick_q      <= tick_d;
      sec_q       <= sec_d;
      first_win_q <= first_win_d;
    end
  end

endmodule

// File: rtl/taho_gate_sched.sv
// Gate scheduler top: snapshots all channel frequencies once per window and streams
// them over valid/ready, tracking per-channel stall and a sticky overrun flag.
module taho_gate_sched
  import taho_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int GATE_TICKS    = 1000000,
  parameter int SEC_HIGH      = 500000,
  parameter int LATCH_DLY     = 4,
  parameter int STALL_WINDOWS = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [TAHO_W*N_CH-1:0]   freq_bus,
  output logic                     sec,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [CH_IDX_W-1:0]      m_ch,
  output logic [TAHO_W-1:0]        m_freq,
  output logic                     m_last,
  output logic [N_CH-1:0]          stall,
  output logic                     overrun,
  input  logic                     overrun_clr,
  output logic [15:0]              window_cnt
);

  localparam logic [CH_IDX_W-1:0] LAST_CH = CH_IDX_W'(N_CH - 1);
  localparam logic [3:0]          STALL_T = 4'(STALL_WINDOWS);

  stream_state_e        state_q, state_d;
  logic [CH_IDX_W-1:0]  ch_q, ch_d;
  logic [TAHO_W-1:0]    snap_q [N_CH];
  logic [TAHO_W-1:0]    snap_d [N_CH];
  logic [3:0]           zcnt_q [N_CH];
  logic [3:0]           zcnt_d [N_CH];
  logic [N_CH-1:0]      stall_q, stall_d;
  logic                 overrun_q, overrun_d;
  logic [15:0]          win_q, win_d;
  logic                 snap_evt;
  logic [TAHO_W-1:0]    freq_sel_s;

  taho_gate_timer #(
    .GATE_TICKS (GATE_TICKS),
    .SEC_HIGH   (SEC_HIGH),
    .LATCH_DLY  (LATCH_DLY)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .sec      (sec),
    .snap_evt (snap_evt)
  );

  // Explicit mux keeps the 4-bit channel index from over-indexing a smaller array.
  always_comb begin
    freq_sel_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_q == CH_IDX_W'(i)) freq_sel_s = snap_q[i];
    end
  end

  assign m_valid    = (state_q == S_SEND);
  assign m_ch       = ch_q;
  assign m_freq     = freq_sel_s;
  assign m_last     = m_valid && (ch_q == LAST_CH);
  assign stall      = stall_q;
  assign overrun    = overrun_q;
  assign window_cnt = win_q;

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    snap_d    = snap_q;
    zcnt_d    = zcnt_q;
    stall_d   = stall_q;
    overrun_d = overrun_q;
    win_d     = win_q;

    case (state_q)
      S_IDLE: ;
      S_SEND: begin
        if (m_ready) begin
          if (ch_q == LAST_CH) begin
            state_d = S_IDLE;
            ch_d    = '0;
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (overrun_clr) overrun_d = 1'b0;

    // A snapshot is only taken from idle; the last-beat cycle still counts as busy.
    if (snap_evt) begin
      win_d = win_q + 16'd1;
      if (state_q == S_IDLE) begin
        state_d = S_SEND;
        ch_d    = '0;
        for (int i = 0; i < N_CH; i++) begin
          snap_d[i] = freq_bus[TAHO_W*i +: TAHO_W];
          if (freq_bus[TAHO_W*i +: TAHO_W] == '0) begin
            zcnt_d[i] = (zcnt_q[i] == 4'd15) ? 4'd15 : zcnt_q[i] + 4'd1;
          end else begin
            zcnt_d[i] = 4'd0;
          end
          stall_d[i] = (zcnt_d[i] >= STALL_T);
        end
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      stall_q   <= '0;
      overrun_q <= 1'b0;
      win_q     <= 16'd0;
      for (int i = 0; i < N_CH; i++) begin
        snap_q[i] <= '0;
        zcnt_q[i] <= 4'd0;
      end
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      stall_q   <= stall_d;
      overrun_q <= overrun_d;
      win_q     <= win_d;
      for (int i = 0; i < N_CH; i++) begin
        snap_q[i] <= snap_d[i];
        zcnt_q[i] <= zcnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_taho_gate_sched.sv
// Randomized bench for taho_gate_sched against a queue-based behavioural model.
module tb_taho_gate_sched;

  localparam int N_CH          = 4;
  localparam int GATE_TICKS    = 20;
  localparam int SEC_HIGH      = 10;
  localparam int LATCH_DLY     = 4;
  localparam int STALL_WINDOWS = 3;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic [16*N_CH-1:0] freq_bus;
  logic              sec;
  logic              m_valid;
  logic              m_ready;
  logic [3:0]        m_ch;
  logic [15:0]       m_freq;
  logic              m_last;
  logic [N_CH-1:0]   stall;
  logic              overrun;
  logic              overrun_clr;
  logic [15:0]       window_cnt;

  taho_gate_sched #(
    .N_CH          (N_CH),
    .GATE_TICKS    (GATE_TICKS),
    .SEC_HIGH      (SEC_HIGH),
    .LATCH_DLY     (LATCH_DLY),
    .STALL_WINDOWS (STALL_WINDOWS)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .freq_bus    (freq_bus),
    .sec         (sec),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_ch        (m_ch),
    .m_freq      (m_freq),
    .m_last      (m_last),
    .stall       (stall),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .window_cnt  (window_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    int ch;
    int freq;
  } beat_t;

  // Reference model: expected beats are a queue filled whole at each accepted window.
  beat_t           mq[$];
  int              mtick;
  bit              msec;
  bit              mfirst;
  bit              mov;
  int              mwin;
  int              mzero[N_CH];
  logic [N_CH-1:0] mstall;

  int n_checks = 0;
  int n_fail   = 0;
  bit cur_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mtick  = 0;
    msec   = 1'b0;
    mfirst = 1'b1;
    mov    = 1'b0;
    mwin   = 0;
    mstall = '0;
    for (int i = 0; i < N_CH; i++) mzero[i] = 0;
  endtask

  task automatic model_step(input bit en, input bit rdy, input bit clr, input logic [16*N_CH-1:0] fb);
    bit ev;
    bit was_empty;
    ev        = en && (mtick == LATCH_DLY);
    was_empty = (mq.size() == 0);
    if (!was_empty && rdy) void'(mq.pop_front());
    if (clr) mov = 1'b0;
    if (ev) begin
      if (mfirst) begin
        mfirst = 1'b0;
      end else begin
        mwin = (mwin + 1) % 65536;
        if (was_empty) begin
          for (int i = 0; i < N_CH; i++) begin
            beat_t b;
            int v;
            v      = int'(fb[16*i +: 16]);
            b.ch   = i;
            b.freq = v;
            mq.push_back(b);
            if (v == 0) mzero[i] = (mzero[i] >= 15) ? 15 : mzero[i] + 1;
            else        mzero[i] = 0;
            mstall[i] = (mzero[i] >= STALL_WINDOWS);
          end
        end else begin
          mov = 1'b1;
        end
      end
    end
    if (!en) mfirst = 1'b1;
    msec  = en && (mtick < SEC_HIGH);
    mtick = en ? (mtick + 1) % GATE_TICKS : 0;
  endtask

  task automatic compare_all();
    check("sec", 32'(sec), 32'(msec));
    check("m_valid", 32'(m_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      check("m_ch", 32'(m_ch), 32'(mq[0].ch));
      check("m_freq", 32'(m_freq), 32'(mq[0].freq));
      check("m_last", 32'(m_last), 32'(mq[0].ch == N_CH - 1));
    end else begin
      check("m_last_idle", 32'(m_last), 32'd0);
    end
    check("stall", 32'(stall), 32'(mstall));
    check("overrun", 32'(overrun), 32'(mov));
    check("window_cnt", 32'(window_cnt), 32'(mwin));
  endtask

  task automatic cyc(input bit en, input bit rdy, input bit clr, input logic [16*N_CH-1:0] fb);
    @(negedge clock);
    compare_all();
    enable      = en;
    m_ready     = rdy;
    overrun_clr = clr;
    freq_bus    = fb;
    model_step(en, rdy, clr, fb);
  endtask

  function automatic logic [16*N_CH-1:0] rand_fb(input int zero_pct);
    logic [16*N_CH-1:0] fb;
    for (int i = 0; i < N_CH; i++) begin
      if ($urandom_range(99) < zero_pct) fb[16*i +: 16] = 16'd0;
      else                                fb[16*i +: 16] = 16'($urandom_range(1, 65535));
    end
    return fb;
  endfunction

  task automatic run_phase(input int n, input int rdy_pct, input int clr_pct,
                           input int tog_pct, input int zero_pct);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(99) < tog_pct) cur_en = ~cur_en;
      cyc(cur_en, $urandom_range(99) < rdy_pct, $urandom_range(99) < clr_pct, rand_fb(zero_pct));
    end
  endtask

  initial begin
    bit found;
    reset       = 1'b1;
    enable      = 1'b0;
    m_ready     = 1'b0;
    overrun_clr = 1'b0;
    freq_bus    = '0;
    model_reset();
    repeat (2) @(negedge clock);
    compare_all();
    reset = 1'b0;

    // Constant frequencies with an always-ready sink.
    cur_en = 1'b1;
    for (int k = 0; k < 60; k++) cyc(1'b1, 1'b1, 1'b0, {16'd40, 16'd30, 16'd20, 16'd10});

    run_phase(300, 75, 6, 0, 50);
    run_phase(300, 20, 5, 0, 50);
    run_phase(400, 50, 5, 3, 40);

    // Bring up a stream and hit it with asynchronous reset mid-frame.
    cur_en = 1'b1;
    found  = 1'b0;
    for (int k = 0; k < 120 && !found; k++) begin
      cyc(1'b1, $urandom_range(1), 1'b0, rand_fb(20));
      if (mq.size() >= 2 && mq.size() < N_CH) found = 1'b1;
    end
    check("midstream_wait", 32'(found), 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clock);
    reset       = 1'b0;
    enable      = 1'b0;
    m_ready     = 1'b1;
    overrun_clr = 1'b0;
    model_step(1'b0, 1'b1, 1'b0, freq_bus);
    cur_en = 1'b1;
    run_phase(300, 60, 5, 1, 45);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
